cache_bus_requester: RTL and testbench
======================================

CACHE_BUS_REQUESTER -- requirements
Module: cache_bus_requester

Interface
REQ-001 The block SHALL have a parameter CPU_ID, default 0, giving the requesting CPU index; it is also the bus_msg source and the xbar destination match value.
REQ-002 The block SHALL have a parameter TIMEOUT, default 16, giving the maximum cycles spent in WAIT_DATA before abort.
REQ-003 The block SHALL have input clk, 1 bit: clock.
REQ-004 The block SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have input req_valid, 1 bit: cache controller miss/upgrade/writeback request.
REQ-006 The block SHALL have output req_ready, 1 bit: request accepted this cycle.
REQ-007 The block SHALL have input req_tx, bus_tx_t: Bus_Rd, Bus_Rdx, Bus_Upg or Bus_Flush.
REQ-008 The block SHALL have input req_addr, XLEN bits: line address.
REQ-009 The block SHALL have input req_data, CACHELINE_SIZE bits: writeback data; used for Bus_Flush only.
REQ-010 The block SHALL have output bus_req, 1 bit: request to the bus arbiter.
REQ-011 The block SHALL have input bus_gnt, 1 bit: arbiter grant.
REQ-012 The block SHALL have output bus_msg, bus_msg_t: snoop-bus broadcast.
REQ-013 The block SHALL have input xbar_in, xbar_msg_t: data return from memory or a peer.
REQ-014 The block SHALL have output xbar_out, xbar_msg_t: flush data to memory.
REQ-015 The block SHALL have output resp_valid, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have output resp_data, CACHELINE_SIZE bits: fill data.
REQ-017 The block SHALL have output resp_err, 1 bit: completion was a timeout.

Function
REQ-018 The FSM SHALL have the states IDLE, ARB, ISSUE, WAIT_DATA and DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-020 On acceptance, tx, addr and data SHALL be latched, and the FSM SHALL move to ARB.
REQ-021 In ARB, bus_req SHALL be 1, held until the cycle bus_gnt is seen; bus_gnt sampled in IDLE SHALL be ignored.
REQ-022 On bus_gnt in ARB, the FSM SHALL move to ISSUE.
REQ-023 In ISSUE, for exactly one cycle, bus_msg.valid SHALL be 1, with bus_tx, addr, and source=CPU_ID.
REQ-024 For Bus_Flush in ISSUE, xbar_out SHALL also be driven that same cycle: valid=1, addr, data=latched data, destination=NUM_CPUS.
REQ-025 From ISSUE, Bus_Rd and Bus_Rdx SHALL go to WAIT_DATA; Bus_Upg and Bus_Flush SHALL go to DONE with resp_data=0.
REQ-026 In WAIT_DATA, a response SHALL be accepted only when xbar_in.valid, destination==CPU_ID and addr==latched addr; otherwise xbar_in is ignored.
REQ-027 On acceptance, the data SHALL be captured into resp_data and the FSM SHALL move to DONE.
REQ-028 Minimum latency with memory responding SHALL be: ISSUE at cycle t, data at t+1, resp_valid at t+2.
REQ-029 A wait counter SHALL clear on entry to WAIT_DATA and increment each cycle in WAIT_DATA.
REQ-030 When the wait counter reaches TIMEOUT-1 with no match, the FSM SHALL go to DONE with resp_err=1 and resp_data=0.
REQ-031 A match in the same cycle as the timeout SHALL win, giving resp_err=0.
REQ-032 In DONE, resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-033 Back-to-back requests SHALL be separated by at least one IDLE cycle.
REQ-034 All outputs except req_ready SHALL be registered; req_ready SHALL be decoded from state.
REQ-035 bus_msg and xbar_out SHALL be all-zero whenever not in ISSUE.
REQ-036 An unknown req_tx SHALL be treated as Bus_Upg.

Reset
REQ-037 Reset SHALL override all activity, including mid-transaction.
REQ-038 On reset: state=IDLE, bus_req=0, bus_msg='0, xbar_out='0, resp_valid=0, resp_err=0, resp_data=0, and the counter and latches cleared.
REQ-039 A response arriving after reset SHALL be ignored.

Structure
REQ-040 bus_tx_t, bus_msg_t, xbar_msg_t, NUM_CPUS, XLEN and CACHELINE_SIZE SHALL come from the shared types package.
REQ-041 The state enum SHALL be local to the block.
REQ-042 There SHALL be no sub-module; the timeout counter SHALL be inline.

Verification
REQ-043 Bus_Rd, addr 5, grant after 2 cycles, memory returns data 5 one cycle after ISSUE -> one bus_msg pulse with source=CPU_ID; resp_valid with resp_data=5 and resp_err=0, 2 cycles after ISSUE.
REQ-044 Bus_Flush, addr 3, data 0xA5 -> bus_msg and xbar_out (destination=NUM_CPUS, data=0xA5) valid in the same cycle; resp_valid next cycle; no wait.
REQ-045 Bus_Rdx, addr 7, with the xbar_in response first addressed to another CPU, then to addr 6, then correct -> only the third response is completed.
REQ-046 Bus_Rd with no response -> resp_valid with resp_err=1 exactly TIMEOUT cycles after entering WAIT_DATA.
REQ-047 rst asserted in WAIT_DATA, then the late response arrives -> outputs zero, state IDLE, no resp_valid.
REQ-048 bus_gnt held high in IDLE, then Bus_Upg requested -> exactly one bus_msg; resp_valid next cycle, resp_data=0.

Source files
------------

// File: rtl/cache_bus_requester_pkg.sv
// Shared bus/crossbar types for the cache bus requester.
//   NUM_CPUS       : number of CPUs; destination NUM_CPUS addresses memory
//   XLEN           : line address width
//   CACHELINE_SIZE : cache line width in bits
//   bus_tx_t       : snoop-bus transaction kind
//   bus_msg_t      : snoop-bus broadcast message
//   xbar_msg_t     : crossbar data message (fills and writebacks)
package cache_bus_requester_pkg;

  localparam int NUM_CPUS       = 4;
  localparam int XLEN           = 32;
  localparam int CACHELINE_SIZE = 64;
  // One extra id so that memory (id NUM_CPUS) is addressable.
  localparam int ID_W           = $clog2(NUM_CPUS + 1);

  typedef enum logic [2:0] {
    BUS_RD    = 3'd0,
    BUS_RDX   = 3'd1,
    BUS_UPG   = 3'd2,
    BUS_FLUSH = 3'd3
  } bus_tx_t;

  typedef struct packed {
    logic             valid;
    bus_tx_t          bus_tx;
    logic [XLEN-1:0]  addr;
    logic [ID_W-1:0]  source;
  } bus_msg_t;

  typedef struct packed {
    logic                      valid;
    logic [XLEN-1:0]           addr;
    logic [CACHELINE_SIZE-1:0] data;
    logic [ID_W-1:0]           destination;
  } xbar_msg_t;

  // Encodings outside the defined set behave as an upgrade (no data moved).
  function automatic bus_tx_t norm_tx(input bus_tx_t t);
    case (t)
      BUS_RD, BUS_RDX, BUS_FLUSH: return t;
      default:                    return BUS_UPG;
    endcase
  endfunction

endpackage

// File: rtl/cache_bus_requester.sv
// Cache-side bus requester: accepts one miss/upgrade/writeback request from
// the cache controller, arbitrates for the snoop bus, broadcasts the message,
// and for reads waits (with timeout) for the fill data on the crossbar.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only when idle)
//   req_tx/addr/data      : transaction kind, line address, writeback data
//   bus_req/bus_gnt       : bus arbiter handshake
//   bus_msg               : snoop-bus broadcast, valid for one cycle
//   xbar_in               : fill data returned from memory or a peer
//   xbar_out              : writeback data to memory (Bus_Flush only)
//   resp_valid/data/err   : one-cycle completion, fill data, timeout flag
module cache_bus_requester
  import cache_bus_requester_pkg::*;
#(
  parameter int CPU_ID  = 0,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  bus_tx_t                   req_tx,
  input  logic [XLEN-1:0]           req_addr,
  input  logic [CACHELINE_SIZE-1:0] req_data,
  output logic                      bus_req,
  input  logic                      bus_gnt,
  output bus_msg_t                  bus_msg,
  input  xbar_msg_t                 xbar_in,
  output xbar_msg_t                 xbar_out,
  output logic                      resp_valid,
  output logic [CACHELINE_SIZE-1:0] resp_data,
  output logic                      resp_err
);

  localparam int              CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [ID_W-1:0] SELF   = ID_W'(CPU_ID);
  localparam logic [ID_W-1:0] MEM_ID = ID_W'(NUM_CPUS);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    WAIT_DATA,
    DONE
  } state_t;

  state_t                    state, state_nxt;
  bus_tx_t                   tx_q;
  logic [XLEN-1:0]           addr_q;
  logic [CACHELINE_SIZE-1:0] data_q;
  logic [CNT_W-1:0]          wait_cnt;
  logic                      rsp_match;
  logic                      timeout_hit;
  logic                      is_read;

  assign req_ready   = (state == IDLE);
  assign is_read     = (tx_q == BUS_RD) || (tx_q == BUS_RDX);
  assign rsp_match   = xbar_in.valid && (xbar_in.destination == SELF) &&
                       (xbar_in.addr == addr_q);
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req_valid) state_nxt = ARB;
      ARB:       if (bus_gnt) state_nxt = ISSUE;
      ISSUE:     state_nxt = is_read ? WAIT_DATA : DONE;
      // A match on the last wait cycle still completes with data.
      WAIT_DATA: if (rsp_match || timeout_hit) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Every output is registered from the next-state decode so it lines up
  // with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_q       <= BUS_RD;
      addr_q     <= '0;
      data_q     <= '0;
      wait_cnt   <= '0;
      bus_req    <= 1'b0;
      bus_msg    <= '0;
      xbar_out   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && req_valid) begin
        tx_q   <= norm_tx(req_tx);
        addr_q <= req_addr;
        data_q <= req_data;
      end

      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT_DATA) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      bus_req <= (state_nxt == ARB);

      bus_msg  <= '0;
      xbar_out <= '0;
      if (state_nxt == ISSUE) begin
        bus_msg.valid  <= 1'b1;
        bus_msg.bus_tx <= tx_q;
        bus_msg.addr   <= addr_q;
        bus_msg.source <= SELF;
        if (tx_q == BUS_FLUSH) begin
          xbar_out.valid       <= 1'b1;
          xbar_out.addr        <= addr_q;
          xbar_out.data        <= data_q;
          xbar_out.destination <= MEM_ID;
        end
      end

      resp_valid <= (state_nxt == DONE);
      resp_data  <= '0;
      resp_err   <= 1'b0;
      if (state == WAIT_DATA) begin
        if (rsp_match) begin
          resp_data <= xbar_in.data;
        end else if (timeout_hit) begin
          resp_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_bus_requester.sv
module tb_cache_bus_requester;
  import cache_bus_requester_pkg::*;

  localparam int CPU = 2;
  localparam int TO  = 6;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      req_valid;
  logic                      req_ready;
  bus_tx_t                   req_tx;
  logic [XLEN-1:0]           req_addr;
  logic [CACHELINE_SIZE-1:0] req_data;
  logic                      bus_req;
  logic                      bus_gnt;
  bus_msg_t                  bus_msg;
  xbar_msg_t                 xbar_in;
  xbar_msg_t                 xbar_out;
  logic                      resp_valid;
  logic [CACHELINE_SIZE-1:0] resp_data;
  logic                      resp_err;

  int errors = 0;
  int checks = 0;

  cache_bus_requester #(.CPU_ID(CPU), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tx(req_tx),
    .req_addr(req_addr), .req_data(req_data),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_msg(bus_msg),
    .xbar_in(xbar_in), .xbar_out(xbar_out),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_xbar();
    xbar_in.valid       = 1'b0;
    xbar_in.addr        = '0;
    xbar_in.data        = '0;
    xbar_in.destination = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".bus_req"}, 128'(bus_req), 128'(0));
    check({tag, ".bus_msg"}, 128'(bus_msg), 128'(0));
    check({tag, ".xbar_out"}, 128'(xbar_out), 128'(0));
    check({tag, ".resp_valid"}, 128'(resp_valid), 128'(0));
    check({tag, ".resp_data"}, 128'(resp_data), 128'(0));
    check({tag, ".resp_err"}, 128'(resp_err), 128'(0));
    check({tag, ".req_ready"}, 128'(req_ready), 128'(1));
  endtask

  // One transaction from the requester's point of view, starting with the
  // requester idle just after a clock edge.
  //   g      : ARB cycles without grant before the grant cycle
  //   r      : cycles after entering the wait before the real response
  //            (r >= TO means it never comes in time)
  //   ndecoy : non-matching responses sent before the real one
  //   ksel   : rotation of decoy kinds (wrong dest, wrong addr, valid=0)
  task automatic run_txn(input string tag, input bus_tx_t tx,
                         input logic [XLEN-1:0] addr,
                         input logic [CACHELINE_SIZE-1:0] data,
                         input int g, input int r, input int ndecoy,
                         input int ksel, input bit pre_gnt);
    bit                        rd;
    bit                        flush;
    bus_tx_t                   etx;
    int                        iss, rc, k;
    logic [CACHELINE_SIZE-1:0] fill, edata;
    bit                        eerr;
    bus_msg_t                  em;
    xbar_msg_t                 ex;

    rd    = (tx == BUS_RD) || (tx == BUS_RDX);
    flush = (tx == BUS_FLUSH);
    etx   = (rd || flush) ? tx : BUS_UPG;
    fill  = {$urandom, $urandom};
    iss   = 2 + g;
    if (!rd) begin
      rc = iss + 1; edata = '0; eerr = 1'b0;
    end else if (r < TO) begin
      rc = iss + 2 + r; edata = fill; eerr = 1'b0;
    end else begin
      rc = iss + 1 + TO; edata = '0; eerr = 1'b1;
    end

    for (int c = 0; c <= rc + 1; c++) begin
      req_valid = (c == 0);
      if (c == 0) begin
        req_tx = tx; req_addr = addr; req_data = data;
      end else begin
        req_tx   = bus_tx_t'($urandom_range(0, 7));
        req_addr = $urandom;
        req_data = {$urandom, $urandom};
      end
      if (c == 0)        bus_gnt = pre_gnt;
      else if (c < iss)  bus_gnt = (c == 1 + g);
      else               bus_gnt = 1'($urandom);

      clear_xbar();
      k = c - (iss + 1);
      if (rd && k >= 0 && k < TO) begin
        if (k == r) begin
          xbar_in.valid = 1'b1; xbar_in.addr = addr;
          xbar_in.data = fill; xbar_in.destination = ID_W'(CPU);
        end else if (k < r && k < ndecoy) begin
          xbar_in.valid = 1'b1; xbar_in.addr = addr;
          xbar_in.data = {$urandom, $urandom};
          xbar_in.destination = ID_W'(CPU);
          case ((ksel + k) % 3)
            0:       xbar_in.destination = ID_W'(CPU + 1);
            1:       xbar_in.addr = addr ^ 32'h1;
            default: xbar_in.valid = 1'b0;
          endcase
        end
      end

      @(negedge clk);
      em = '0;
      ex = '0;
      if (c == iss) begin
        em.valid = 1'b1; em.bus_tx = etx; em.addr = addr;
        em.source = ID_W'(CPU);
        if (flush) begin
          ex.valid = 1'b1; ex.addr = addr; ex.data = data;
          ex.destination = ID_W'(NUM_CPUS);
        end
      end
      check({tag, ".req_ready"}, 128'(req_ready), 128'(c == 0 || c > rc));
      check({tag, ".bus_req"}, 128'(bus_req), 128'(c >= 1 && c < iss));
      check({tag, ".bus_msg"}, 128'(bus_msg), 128'(em));
      check({tag, ".xbar_out"}, 128'(xbar_out), 128'(ex));
      check({tag, ".resp_valid"}, 128'(resp_valid), 128'(c == rc));
      check({tag, ".resp_data"}, 128'(resp_data),
            (c == rc) ? 128'(edata) : 128'(0));
      check({tag, ".resp_err"}, 128'(resp_err), 128'((c == rc) && eerr));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    bus_gnt   = 1'b0;
    clear_xbar();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_tx = BUS_RD; req_addr = '0;
    req_data = '0; bus_gnt = 1'b0;
    clear_xbar();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_txn("rd_basic", BUS_RD, 32'd5, '0, 2, 0, 0, 0, 1'b0);
    // The directed fill data must be exactly 5: run it once more by hand.
    begin
      req_valid = 1'b1; req_tx = BUS_RD; req_addr = 32'd5;
      @(posedge clk); #1;
      req_valid = 1'b0; bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      @(negedge clk);
      check("rd5.issue", 128'(bus_msg.valid), 128'(1));
      @(posedge clk); #1;
      xbar_in.valid = 1'b1; xbar_in.addr = 32'd5; xbar_in.data = 64'd5;
      xbar_in.destination = ID_W'(CPU);
      @(posedge clk); #1;
      clear_xbar();
      @(negedge clk);
      check("rd5.resp_valid", 128'(resp_valid), 128'(1));
      check("rd5.resp_data", 128'(resp_data), 128'(5));
      check("rd5.resp_err", 128'(resp_err), 128'(0));
      @(posedge clk); #1;
    end

    run_txn("flush", BUS_FLUSH, 32'd3, 64'hA5, 0, 0, 0, 0, 1'b0);
    run_txn("rdx_decoy", BUS_RDX, 32'd7, '0, 1, 2, 2, 0, 1'b0);
    run_txn("rd_timeout", BUS_RD, 32'h40, '0, 0, 1000, 3, 1, 1'b0);
    run_txn("rd_last_cycle", BUS_RD, 32'h44, '0, 1, TO - 1, 5, 2, 1'b0);
    run_txn("rd_one_late", BUS_RD, 32'h48, '0, 0, TO, 0, 0, 1'b0);
    run_txn("upg_gnt_idle", BUS_UPG, 32'h80, 64'hFFFF, 0, 0, 0, 0, 1'b1);
    run_txn("unknown_tx", bus_tx_t'(3'd6), 32'h90, 64'h1234, 1, 0, 0, 0, 1'b0);

    // Reset in the middle of a wait; the late response must be ignored.
    req_valid = 1'b1; req_tx = BUS_RDX; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid");
    for (int i = 0; i < 4; i++) begin
      xbar_in.valid = (i < 2); xbar_in.addr = 32'h100;
      xbar_in.data = 64'hDEAD; xbar_in.destination = ID_W'(CPU);
      @(posedge clk); #1;
      @(negedge clk);
      check_quiet("rst_late");
    end
    @(posedge clk); #1;
    clear_xbar();

    for (int n = 0; n < 14; n++) begin
      run_txn("rand", bus_tx_t'($urandom_range(0, 7)), $urandom,
              {$urandom, $urandom}, $urandom_range(0, 3),
              $urandom_range(0, TO + 1), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
